// File: rtl/vga_fetch_arbiter_if.sv
// Memory + CPU bus bundle for vga_fetch_arbiter.
// slave  : the arbiter side (drives memory strobes and CPU completion).
// master : the environment side (memory model and CPU requester).
interface vga_fetch_arbiter_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 32
);
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;

  modport slave (
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack
  );

  modport master (
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack
  );
endinterface

// File: rtl/vga_fetch_arbiter.sv
// vga_fetch_arbiter: shares a single-port display RAM (1-cycle read latency)
// between the VGA pixel fetch and a CPU load/store port. Fetch owns fixed
// slots one word ahead of the pixels; the CPU takes any other cycle.
// Fetched words are unpacked LSB-first, one pixel per clock; timer sync and
// bright are delayed one cycle to match.
// Optional: define VGA_ARB_BLANK_ONLY_EN to restrict CPU grants to cycles
// outside the visible fetch/display window (tear-free updates).
// WORD_PIX must be a power of two, at least 2.
module vga_fetch_arbiter #(
  parameter int PIX_W    = 8,
  parameter int WORD_PIX = 4,
  parameter int H_START  = 144,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 17
) (
  input  logic               clk,
  input  logic               clear,
  input  logic [9:0]         hcount,
  input  logic [9:0]         vcount,
  input  logic               bright,
  input  logic               hsync,
  input  logic               vsync,
  output logic [PIX_W-1:0]   pix_data,
  output logic               pix_bright,
  output logic               pix_hsync,
  output logic               pix_vsync,
  vga_fetch_arbiter_if.slave bus
);
  localparam int DATA_W = PIX_W * WORD_PIX;
  localparam int WPL    = H_ACTIVE / WORD_PIX;
  localparam int SEL_W  = $clog2(WORD_PIX);

  // Window bounds in a common 16-bit width so comparisons stay width-clean.
  localparam logic [15:0] FS_LO = 16'(H_START - WORD_PIX);
  localparam logic [15:0] FS_HI = 16'(H_START + H_ACTIVE - 2*WORD_PIX);
  localparam logic [15:0] AC_LO = 16'(H_START);
  localparam logic [15:0] AC_HI = 16'(H_START + H_ACTIVE - 1);
  localparam logic [15:0] V_END = 16'(V_ACTIVE);

  typedef enum logic [1:0] {IDLE, WR_ACK, RD_WAIT, RD_ACK} state_t;

  state_t              state, state_nxt;
  logic [15:0]         hc, vc, hoff;
  logic [SEL_W-1:0]    pj;
  logic                vis_line, slot, active, cpu_ok;
  logic [ADDR_W-1:0]   fetch_addr;
  logic                fetch_tag;
  logic [DATA_W-1:0]   next_word, cur_word, cpu_rdata_q;

  logic                mem_en_c, mem_we_c, cpu_ack_c;
  logic [ADDR_W-1:0]   mem_addr_c;
  logic [DATA_W-1:0]   mem_wdata_c;

  assign hc       = 16'(hcount);
  assign vc       = 16'(vcount);
  assign vis_line = vc < V_END;
  assign hoff     = hc - FS_LO;
  // Slots sit one word ahead of the pixels they feed: H_START-WORD_PIX+WORD_PIX*k.
  assign slot     = vis_line && (hc >= FS_LO) && (hc <= FS_HI) && (hoff[SEL_W-1:0] == '0);
  assign active   = vis_line && (hc >= AC_LO) && (hc <= AC_HI);
  assign pj       = SEL_W'(hc - AC_LO);
  assign fetch_addr = ADDR_W'(vc) * ADDR_W'(WPL) + ADDR_W'(hoff >> SEL_W);

`ifdef VGA_ARB_BLANK_ONLY_EN
  assign cpu_ok = !vis_line || (hc < FS_LO) || (hc > AC_HI);
`else
  assign cpu_ok = 1'b1;
`endif

  // Memory port mux and CPU FSM next state; fetch slot always wins the port.
  always_comb begin
    state_nxt   = state;
    mem_en_c    = 1'b0;
    mem_we_c    = 1'b0;
    mem_addr_c  = '0;
    mem_wdata_c = '0;
    cpu_ack_c   = 1'b0;
    if (!clear && slot) begin
      mem_en_c   = 1'b1;
      mem_addr_c = fetch_addr;
    end
    unique case (state)
      IDLE: begin
        if (!clear && bus.cpu_req && !slot && cpu_ok) begin
          mem_en_c    = 1'b1;
          mem_we_c    = bus.cpu_we;
          mem_addr_c  = bus.cpu_addr;
          mem_wdata_c = bus.cpu_wdata;
          state_nxt   = bus.cpu_we ? WR_ACK : RD_WAIT;
        end
      end
      WR_ACK: begin
        cpu_ack_c = 1'b1;
        state_nxt = IDLE;
      end
      RD_WAIT: state_nxt = RD_ACK;
      RD_ACK: begin
        cpu_ack_c = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.mem_en    = mem_en_c;
  assign bus.mem_we    = mem_we_c;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_wdata = mem_wdata_c;
  assign bus.cpu_ack   = cpu_ack_c;
  assign bus.cpu_rdata = cpu_rdata_q;

  // CPU FSM state register; clear abandons any op in flight.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) state <= IDLE;
    else       state <= state_nxt;
  end

  // Tag last cycle's op as fetch so its return data lands in next_word.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      fetch_tag <= 1'b0;
      next_word <= '0;
    end else begin
      fetch_tag <= slot;
      if (fetch_tag) next_word <= bus.mem_rdata;
    end
  end

  // CPU read data is captured in the cycle after its grant.
  always_ff @(posedge clk or posedge clear) begin
    if (clear)                 cpu_rdata_q <= '0;
    else if (state == RD_WAIT) cpu_rdata_q <= bus.mem_rdata;
  end

  // Pixel unpack: lane 0 comes straight from next_word as it is latched.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      pix_data   <= '0;
      cur_word   <= '0;
      pix_bright <= 1'b0;
      pix_hsync  <= 1'b0;
      pix_vsync  <= 1'b0;
    end else begin
      pix_bright <= bright;
      pix_hsync  <= hsync;
      pix_vsync  <= vsync;
      if (!active) begin
        pix_data <= '0;
      end else if (pj == '0) begin
        pix_data <= next_word[PIX_W-1:0];
        cur_word <= next_word;
      end else begin
        pix_data <= PIX_W'(cur_word >> (PIX_W * int'(pj)));
      end
    end
  end
endmodule

// File: doc/vga_fetch_arbiter.md
Name: vga_fetch_arbiter

Overview:
- Shares one single-port display memory (1-cycle read latency) between two requesters:
  - the VGA pixel-fetch path, sequenced from the timer's hcount/vcount;
  - a CPU load/store port.
- Fetch is absolute priority on fixed fetch slots; the CPU uses every other cycle.
- Unpacks fetched words into one pixel per clock, with sync/bright delayed to stay aligned.
- Sits between the VGA timer, the display RAM and the CPU bus.

Parameters:
- PIX_W, 8, bits per pixel
- WORD_PIX, 4, pixels per memory word (power of 2); DATA_W = PIX_W*WORD_PIX
- H_START, 144, first active hcount
- H_ACTIVE, 640, active pixels per line; WORDS_PER_LINE = H_ACTIVE/WORD_PIX
- V_ACTIVE, 480, active lines (vcount 0..V_ACTIVE-1)
- ADDR_W, 17, memory word address width

Ports:
- clk  in  1  system/pixel clock, rising edge
- clear  in  1  reset, asynchronous, active-high
- hcount  in  10  timer horizontal count
- vcount  in  10  timer vertical count
- bright, hsync, vsync  in  1 each  timer outputs
- pix_data  out  PIX_W  pixel for current cycle
- pix_bright, pix_hsync, pix_vsync  out  1 each  bright/hsync/vsync delayed 1 cycle
- mem_en, mem_we  out  1 each  memory strobe / write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  read data, valid the cycle after mem_en with mem_we=0
- cpu_req  in  1  CPU request; held with addr/we/wdata stable until cpu_ack
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  DATA_W  write data
- cpu_rdata  out  DATA_W  read data, valid while cpu_ack=1
- cpu_ack  out  1  one-cycle completion pulse

Behaviour:
- Reset: all outputs 0; next_word, cur_word, fetch tag cleared; FSM to IDLE. Asserting clear mid-operation drops the in-flight CPU op; no ack is issued.
- Fetch slot:
  - Occurs when vcount < V_ACTIVE and hcount = H_START - WORD_PIX + WORD_PIX*k, k = 0..WORDS_PER_LINE-1 (defaults: hcount 140,144,...,776).
  - Drive mem_en=1, mem_we=0, mem_addr = vcount*WORDS_PER_LINE + k.
  - Set fetch tag; the next cycle's mem_rdata loads next_word.
- Pixel unpack (registered, 1-cycle latency): at the edge sampling hcount = H_START + WORD_PIX*k + j, with j in 0..WORD_PIX-1:
  - j=0: pix_data <= next_word[PIX_W-1:0]; cur_word <= next_word.
  - j>0: pix_data <= cur_word[PIX_W*j +: PIX_W].
  - Pixel 0 is in the LSBs.
  - pix_data <= 0 whenever hcount is outside [H_START, H_START+H_ACTIVE-1] or vcount >= V_ACTIVE.
  - pix_bright/hsync/vsync <= bright/hsync/vsync every cycle.
- CPU FSM, states IDLE, WR_ACK, RD_WAIT, RD_ACK:
  - IDLE: if cpu_req=1 and the cycle is not a fetch slot, grant: mem_en=1, mem_we=cpu_we, mem_addr=cpu_addr, mem_wdata=cpu_wdata. Go to WR_ACK (write) or RD_WAIT (read).
  - IDLE, fetch slot: the fetch wins; the CPU waits. Maximum wait is 1 cycle with default parameters.
  - WR_ACK: cpu_ack=1; go to IDLE.
  - RD_WAIT: capture mem_rdata into cpu_rdata; go to RD_ACK. A fetch slot in this cycle still issues.
  - RD_ACK: cpu_ack=1 with cpu_rdata valid; go to IDLE.
  - No CPU grant in WR_ACK, RD_WAIT or RD_ACK. Write latency 1 cycle after grant; read latency 2.
  - Write and read ack at most once per request; the requester drops cpu_req in the ack cycle or it is treated as a new request.
- Return-data routing: mem_rdata is steered by the 1-cycle-delayed tag (fetch vs CPU). Only one memory op issues per cycle, so no collision.
- Widths: address product computed at ADDR_W, truncated. No CPU address range check.
- When mem_en=0: mem_we, mem_addr, mem_wdata = 0.

Optional Feature:
- Macro VGA_ARB_BLANK_ONLY_EN.
- Defined: CPU grants only when vcount >= V_ACTIVE or hcount is outside [H_START-WORD_PIX, H_START+H_ACTIVE-1] (tear-free writes). A request stalls through the active window.
- Undefined: grant on any non-fetch-slot cycle, as above.

Test Plan:
- Reset mid-read: clear=1 during RD_WAIT -> cpu_ack never pulses; all outputs 0; FSM in IDLE after release.
- Fetch address, vcount=2: fetch at hcount=140 -> mem_addr=320; at hcount=144 -> mem_addr=321. mem_we=0 both.
- Unpack: mem_rdata=32'h44332211 returned for k=0 -> pix_data 11,22,33,44 on cycles after hcount 144..147; pix_data=0 after hcount 143 and 784.
- CPU write colliding with slot: cpu_req, we=1, addr=5, wdata=32'hDEADBEEF at hcount=148 -> fetch at 148; write grant at 149; cpu_ack at 150.
- CPU read in blanking: vcount=479, hcount=790, addr=7, memory holds 32'hCAFEF00D -> grant 790; cpu_ack=1 with cpu_rdata=32'hCAFEF00D at 792.
- VGA_ARB_BLANK_ONLY_EN defined: request at vcount=10, hcount=300 -> no grant until hcount=784; cpu_ack at 785 (write).
